// File: rtl/pattern_blinker.sv
// pattern_blinker: multi-channel run-time-loadable LED pattern sequencer driven by a shared prescaler
// CLK, RST: clock and synchronous active-high reset; enable: run (1) or freeze (0)
// load_valid/load_ready/load_channel/load_pattern/load_oneshot: pattern load port; load_err: bad-channel pulse
// LED: registered per-channel drive; done: per-channel one-shot completion pulse
module pattern_blinker #(
    parameter int CHANNELS = 4,
    parameter int PATTERN_BITS = 32,
    parameter int PRESCALE_BITS = 21,
    parameter logic [31:0] DEFAULT_PATTERN = 32'h02A80000,
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
    localparam int IDX_W = $clog2(PATTERN_BITS)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [CH_W-1:0]         load_channel,
    input  logic [PATTERN_BITS-1:0] load_pattern,
    input  logic                    load_oneshot,
    output logic                    load_err,
    output logic [CHANNELS-1:0]     LED,
    output logic [CHANNELS-1:0]     done
);
    localparam logic [PATTERN_BITS-1:0] DEF = PATTERN_BITS'(DEFAULT_PATTERN);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(PATTERN_BITS - 1);
    logic [PRESCALE_BITS-1:0] presc;
    logic [PATTERN_BITS-1:0] pattern [CHANNELS];
    logic [IDX_W-1:0] idx [CHANNELS];
    logic [CHANNELS-1:0] oneshot, active, done_pend;
    logic rdy_q, tick, accept, bad_ch;
    assign tick = enable & (&presc);
    assign load_ready = rdy_q & ~RST;
    assign accept = load_valid & load_ready;
    assign bad_ch = {1'b0, load_channel} >= (CH_W + 1)'(CHANNELS);
    // done is staged through done_pend so it lines up with the LED going dark;
    // while frozen a pending completion is held and released on re-enable
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc <= '0;
            rdy_q <= 1'b0;
            load_err <= 1'b0;
            oneshot <= '0;
            active <= '1;
            done_pend <= '0;
            done <= '0;
            LED <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                pattern[c] <= DEF;
                idx[c] <= '0;
            end
        end else begin
            rdy_q <= 1'b1;
            load_err <= accept & bad_ch;
            done <= enable ? done_pend : '0;
            if (enable) presc <= presc + PRESCALE_BITS'(1);
            for (int c = 0; c < CHANNELS; c++) begin
                LED[c] <= active[c] & pattern[c][idx[c]];
                if (enable) done_pend[c] <= 1'b0;
                if (accept && !bad_ch && load_channel == CH_W'(c)) begin
                    pattern[c] <= load_pattern;
                    oneshot[c] <= load_oneshot;
                    idx[c] <= '0;
                    active[c] <= 1'b1;
                end else if (tick && active[c]) begin
                    // power-of-two length: the increment wraps LAST back to 0
                    idx[c] <= idx[c] + IDX_W'(1);
                    if (idx[c] == LAST && oneshot[c]) begin
                        active[c] <= 1'b0;
                        done_pend[c] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pattern_blinker.sv
// tb_pattern_blinker: scoreboard bench for pattern_blinker with a 2-channel and a 3-channel instance
module tb_pattern_blinker;
    localparam int PB = 8;
    localparam logic [7:0] DEF = 8'b1010_0110;
    typedef struct packed {
        logic [1:0][2:0] led;
        logic [1:0][2:0] done;
        logic [1:0] err;
        logic [1:0] rdy;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, lv = 1'b0, lo = 1'b0;
    logic [1:0] lc = 2'd0;
    logic [7:0] lp = 8'd0;
    logic lv_a, rdy_a, err_a, rdy_b, err_b;
    logic [1:0] led_a, done_a;
    logic [2:0] led_b, done_b;
    int total = 0, passed = 0, i;
    exp_t sq[$];
    logic [7:0] pat[6];
    bit pq[6][$];
    bit osm[6], act[6], dp[6];
    int ec[2];
    bit rdy[2];

    assign lv_a = lv && !lc[1];
    always #5 clk = ~clk;

    pattern_blinker #(.CHANNELS(2), .PATTERN_BITS(8), .PRESCALE_BITS(2), .DEFAULT_PATTERN(32'(DEF))) dut_a (
        .CLK(clk), .RST(rst), .enable(en), .load_valid(lv_a), .load_ready(rdy_a),
        .load_channel(lc[0]), .load_pattern(lp), .load_oneshot(lo), .load_err(err_a),
        .LED(led_a), .done(done_a));

    pattern_blinker #(.CHANNELS(3), .PATTERN_BITS(8), .PRESCALE_BITS(2), .DEFAULT_PATTERN(32'(DEF))) dut_b (
        .CLK(clk), .RST(rst), .enable(en), .load_valid(lv), .load_ready(rdy_b),
        .load_channel(lc), .load_pattern(lp), .load_oneshot(lo), .load_err(err_b),
        .LED(led_b), .done(done_b));

    task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s t=%0t got=%b want=%b", nm, $time, got, want);
    endtask

    // each channel plays its pattern as a queue of bits, front bit on the LED
    task automatic fill(input int k, input logic [7:0] p);
        pat[k] = p;
        pq[k].delete();
        for (int b = 0; b < PB; b++) pq[k].push_back(p[b]);
    endtask

    task automatic model_step();
        exp_t e;
        int n, k;
        bit acc, tk;
        e = '0;
        for (int m = 0; m < 2; m++) begin
            n = m + 2;
            acc = (m == 1 || !lc[1]) && lv && rdy[m] && !rst;
            tk = en && ec[m] == 3;
            e.err[m] = acc && lc >= n;
            for (int c = 0; c < n; c++) begin
                k = m * 3 + c;
                if (rst) begin
                    fill(k, DEF);
                    osm[k] = 0;
                    act[k] = 1;
                    dp[k] = 0;
                end else begin
                    e.led[m][c] = act[k] && pq[k].size() > 0 && pq[k][0];
                    e.done[m][c] = en && dp[k];
                    if (en) dp[k] = 0;
                    if (acc && lc == c) begin
                        fill(k, lp);
                        osm[k] = lo;
                        act[k] = 1;
                    end else if (tk && act[k]) begin
                        void'(pq[k].pop_front());
                        if (pq[k].size() == 0) begin
                            if (osm[k]) begin
                                act[k] = 0;
                                dp[k] = 1;
                            end else fill(k, pat[k]);
                        end
                    end
                end
            end
            ec[m] = rst ? 0 : en ? (ec[m] + 1) % 4 : ec[m];
            rdy[m] = !rst;
            e.rdy[m] = rdy[m];
        end
        sq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load(input logic [1:0] c, input logic [7:0] p, input logic o);
        lc = c;
        lp = p;
        lo = o;
        lv = 1'b1;
        step();
        lv = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (sq.size() > 0) begin
            e = sq.pop_front();
            chk("led_a", {1'b0, led_a}, e.led[0]);
            chk("done_a", {1'b0, done_a}, e.done[0]);
            chk("err_a", {2'b0, err_a}, {2'b0, e.err[0]});
            chk("ready_a", {2'b0, rdy_a}, {2'b0, e.rdy[0] & ~rst});
            chk("led_b", led_b, e.led[1]);
            chk("done_b", done_b, e.done[1]);
            chk("err_b", {2'b0, err_b}, {2'b0, e.err[1]});
            chk("ready_b", {2'b0, rdy_b}, {2'b0, e.rdy[1] & ~rst});
        end
    end

    initial begin
        for (int k = 0; k < 6; k++) fill(k, DEF);
        ec = '{0, 0};
        rdy = '{0, 0};
        repeat (3) step();
        rst = 1'b0;
        en = 1'b1;
        repeat (70) step();
        load(2'd1, 8'hFF, 1'b1);
        repeat (45) step();
        load(2'd1, 8'h3C, 1'b0);
        load(2'd0, 8'hA5, 1'b1);
        i = 0;
        while (!(en && ec[0] == 3 && act[0] && osm[0] && pq[0].size() == 1) && i < 100) begin
            step();
            i++;
        end
        chk("coincident_reach", {2'b0, i < 100}, 3'b001);
        load(2'd0, 8'h01, 1'b0);
        repeat (40) step();
        load(2'd3, 8'h5A, 1'b1);
        repeat (20) step();
        i = 0;
        while (ec[0] != 1 && i < 10) begin
            step();
            i++;
        end
        en = 1'b0;
        repeat (20) step();
        en = 1'b1;
        repeat (20) step();
        load(2'd1, 8'hC3, 1'b1);
        i = 0;
        while (!dp[1] && i < 100) begin
            step();
            i++;
        end
        chk("done_due_reach", {2'b0, i < 100}, 3'b001);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (45) step();
        repeat (500) begin
            rst = $urandom_range(0, 99) == 0;
            en = $urandom_range(0, 9) != 0;
            lv = $urandom_range(0, 3) == 0;
            lc = 2'($urandom_range(0, 3));
            lp = 8'($urandom);
            lo = 1'($urandom);
            step();
        end
        rst = 1'b0;
        lv = 1'b0;
        repeat (3) step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
